mem_sync_responder: RTL and testbench
=====================================

MEM_SYNC_RESPONDER -- requirements
Module: mem_sync_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning): CHWIDTH, 6, emulation row-id width.
REQ-002 SHALL have ADDRWIDTH, 17, memory row-id width.
REQ-003 SHALL have COLWIDTH, 4, log2 of words per row (16 words).
REQ-004 SHALL have DWIDTH, 64, data word width.
REQ-005 SHALL have a single clock `clk` and reset `rst`, with `rst` asynchronous and active-high.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wb_req  in  1  level; write emulation row cRowId back to memory row RowId.
- alloc_req  in  1  level; fetch memory row RowId into emulation row cRowId.
- cRowId  in  CHWIDTH  emulation row.
- RowId  in  ADDRWIDTH  memory row.
- sync  out  1  one-cycle completion pulse.
- busy  out  1  transfer in progress.
- lb_addr  out  CHWIDTH+COLWIDTH  local buffer address {row, word}.
- lb_rd  out  1  local read; lb_rdata valid next cycle.
- lb_rdata  in  DWIDTH  local read data.
- lb_wr  out  1  local write strobe.
- lb_wdata  out  DWIDTH  local write data.
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory command accept.
- mem_cmd_we  out  1  1 = write, 0 = read.
- mem_cmd_addr  out  ADDRWIDTH+COLWIDTH  {row, word}.
- mem_wdata  out  DWIDTH  write data.
- mem_rvalid  in  1  read response valid; responses arrive in order.
- mem_rdata  in  DWIDTH  read response data.

Function
REQ-007 SHALL implement the states Idle, WbRead, WbSend, AlXfer and Done.
REQ-008 In Idle, SHALL go to WbRead if wb_req=1, else to AlXfer if alloc_req=1; wb_req SHALL win when both are set.
REQ-009 On leaving Idle, SHALL latch cRowId and RowId and clear the word counters; later input changes SHALL be ignored until Done.
REQ-010 WbRead: SHALL drive lb_rd=1 for one cycle with lb_addr={row, wcnt}, then go to WbSend.
REQ-011 WbSend: SHALL capture lb_rdata into a hold register on entry, then hold mem_cmd_valid=1, we=1, addr={RowId, wcnt}, mem_wdata stable until mem_cmd_ready=1.
REQ-012 When the WbSend handshake completes, SHALL increment wcnt; if wcnt was 2**COLWIDTH-1 it SHALL go to Done, else back to WbRead.
REQ-013 AlXfer: SHALL issue read commands (we=0) at ccnt, advancing ccnt on each handshake; mem_cmd_valid SHALL drop after the last command.
REQ-014 AlXfer: on each mem_rvalid, SHALL pulse lb_wr=1 with lb_addr={row, rcnt} and lb_wdata=mem_rdata in the same cycle, then increment rcnt.
REQ-015 AlXfer: the last response (rcnt=2**COLWIDTH-1) SHALL go to Done.
REQ-016 A command handshake and a response in the same cycle SHALL both be honoured; lb_wr SHALL take priority on lb_addr, and lb_rd is never used in AlXfer.
REQ-017 Responses arriving before their command is accepted SHALL be ignored; rcnt SHALL never exceed ccnt.
REQ-018 Counters SHALL be COLWIDTH bits and wrap to 0 after the last word.
REQ-019 Done: SHALL assert sync=1 for exactly one cycle, then go to Idle.
REQ-020 The requester SHALL drop its request at the clock edge that samples sync; in Idle a request SHALL be treated as new.
REQ-021 busy SHALL be 1 in every state except Idle.
REQ-022 Write-back latency SHALL be at least 2*2**COLWIDTH+1 cycles from request to sync; allocate latency SHALL be at least 2**COLWIDTH+2 cycles.

Reset
REQ-023 While rst=1, SHALL hold state=Idle and drive sync, busy, lb_rd, lb_wr, mem_cmd_valid and mem_cmd_we to 0, and all counters, latched ids and data/address outputs to 0.
REQ-024 Reset mid-transfer SHALL abort immediately with no sync pulse and no further local or memory traffic.

Structure
REQ-025 SHALL place the state enum and the default widths in the shared package mem_sync_pkg, which is also used by the sync controller.
REQ-026 SHALL be a single module with no sub-modules; the counters and hold register SHALL be inline.

Verification
REQ-027 SHALL cover write-back with cRowId=5, RowId=0x1A2B3, mem_cmd_ready always 1: 16 writes to addrs 0x1A2B30..0x1A2B3F carrying local data of row 5 in order, then one sync pulse.
REQ-028 SHALL cover write-back with ready low for 3 cycles per word: mem_wdata and addr stable while stalled, no word duplicated or skipped, sync after the last word.
REQ-029 SHALL cover allocate with cRowId=63, RowId=0, rvalid 2 cycles after each command: lb_wr at 0x3F0..0x3FF with mem_rdata in order, then sync.
REQ-030 SHALL cover wb_req and alloc_req raised together: write-back first with sync, then alloc_req alone starting a fresh transfer with a second sync.
REQ-031 SHALL cover rst asserted at word 7 of an allocate: all outputs 0 immediately, no sync; the next request restarts at word 0.
REQ-032 SHALL cover a response arriving in the same cycle as a command handshake: both counters advance, and the final rcnt/ccnt are both 0 after wrap.

Source files
------------

// File: rtl/mem_sync_pkg.sv
// Shared definitions for the memory sync responder and its sync controller.
// Holds the transfer state encoding and the default geometry of the
// emulation buffer (rows x words) and of the backing memory.
package mem_sync_pkg;

    localparam int unsigned CHWIDTH_DEF   = 6;   // emulation row-id width
    localparam int unsigned ADDRWIDTH_DEF = 17;  // memory row-id width
    localparam int unsigned COLWIDTH_DEF  = 4;   // log2 of words per row
    localparam int unsigned DWIDTH_DEF    = 64;  // data word width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_READ,
        ST_WB_SEND,
        ST_AL_XFER,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_sync_responder_if.sv
// Bus bundle between a requester / local buffer / memory port and the
// mem_sync_responder.
//   request side : wb_req, alloc_req, cRowId, RowId -> ; <- sync, busy
//   local buffer : <- lb_addr, lb_rd, lb_wr, lb_wdata ; lb_rdata ->
//   memory       : <- mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata
//                  mem_cmd_ready, mem_rvalid, mem_rdata ->
// modport slave is the responder; modport master is its environment.
interface mem_sync_responder_if
    import mem_sync_pkg::*;
#(
    parameter int unsigned CHWIDTH   = CHWIDTH_DEF,
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int unsigned COLWIDTH  = COLWIDTH_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF
) ();

    logic                          wb_req;
    logic                          alloc_req;
    logic [CHWIDTH-1:0]            cRowId;
    logic [ADDRWIDTH-1:0]          RowId;
    logic                          sync;
    logic                          busy;

    logic [CHWIDTH+COLWIDTH-1:0]   lb_addr;
    logic                          lb_rd;
    logic [DWIDTH-1:0]             lb_rdata;
    logic                          lb_wr;
    logic [DWIDTH-1:0]             lb_wdata;

    logic                          mem_cmd_valid;
    logic                          mem_cmd_ready;
    logic                          mem_cmd_we;
    logic [ADDRWIDTH+COLWIDTH-1:0] mem_cmd_addr;
    logic [DWIDTH-1:0]             mem_wdata;
    logic                          mem_rvalid;
    logic [DWIDTH-1:0]             mem_rdata;

    modport slave (
        input  wb_req, alloc_req, cRowId, RowId, lb_rdata,
               mem_cmd_ready, mem_rvalid, mem_rdata,
        output sync, busy, lb_addr, lb_rd, lb_wr, lb_wdata,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata
    );

    modport master (
        output wb_req, alloc_req, cRowId, RowId, lb_rdata,
               mem_cmd_ready, mem_rvalid, mem_rdata,
        input  sync, busy, lb_addr, lb_rd, lb_wr, lb_wdata,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata
    );

endinterface

// File: rtl/mem_sync_responder.sv
// Moves one row of 2**COLWIDTH words between the emulation local buffer
// and backing memory.
//   wb_req    : copy local row cRowId to memory row RowId (read, then write
//               each word in turn).
//   alloc_req : copy memory row RowId into local row cRowId (read commands
//               pipelined, in-order responses written straight to the buffer).
// sync pulses for one cycle when a transfer finishes; busy is high outside
// Idle. clk / rst (async, active-high) are plain ports, all else is on bus.
module mem_sync_responder
    import mem_sync_pkg::*;
#(
    parameter int unsigned CHWIDTH   = CHWIDTH_DEF,
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int unsigned COLWIDTH  = COLWIDTH_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_sync_responder_if.slave bus
);

    localparam int unsigned LAW = CHWIDTH + COLWIDTH;
    localparam int unsigned MAW = ADDRWIDTH + COLWIDTH;

    state_e                state_q, state_d;
    logic [CHWIDTH-1:0]    row_q, row_d;
    logic [ADDRWIDTH-1:0]  rowid_q, rowid_d;
    logic [COLWIDTH-1:0]   wcnt_q, wcnt_d;
    logic [COLWIDTH-1:0]   ccnt_q, ccnt_d;
    logic [COLWIDTH-1:0]   rcnt_q, rcnt_d;
    logic [DWIDTH-1:0]     hold_q, hold_d;
    logic                  first_q, first_d;   // first cycle of WbSend
    logic                  cdone_q, cdone_d;   // all read commands issued

    logic                  sync_c, busy_c, lb_rd_c, lb_wr_c;
    logic                  cmd_valid_c, cmd_we_c;
    logic [LAW-1:0]        lb_addr_c;
    logic [DWIDTH-1:0]     lb_wdata_c, mem_wdata_c;
    logic [MAW-1:0]        cmd_addr_c;
    logic                  rsp_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            rowid_q <= '0;
            wcnt_q  <= '0;
            ccnt_q  <= '0;
            rcnt_q  <= '0;
            hold_q  <= '0;
            first_q <= 1'b0;
            cdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rowid_q <= rowid_d;
            wcnt_q  <= wcnt_d;
            ccnt_q  <= ccnt_d;
            rcnt_q  <= rcnt_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            cdone_q <= cdone_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        rowid_d     = rowid_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        rcnt_d      = rcnt_q;
        hold_d      = hold_q;
        first_d     = 1'b0;
        cdone_d     = cdone_q;
        sync_c      = 1'b0;
        busy_c      = (state_q != ST_IDLE);
        lb_rd_c     = 1'b0;
        lb_wr_c     = 1'b0;
        lb_addr_c   = '0;
        lb_wdata_c  = '0;
        cmd_valid_c = 1'b0;
        cmd_we_c    = 1'b0;
        cmd_addr_c  = '0;
        mem_wdata_c = '0;
        // A response is only real once its command has been accepted; once
        // every command is out, ccnt has wrapped and cdone covers the rest.
        rsp_ok      = bus.mem_rvalid && (cdone_q || (rcnt_q != ccnt_q));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wb_req || bus.alloc_req) begin
                    state_d = bus.wb_req ? ST_WB_READ : ST_AL_XFER;
                    row_d   = bus.cRowId;
                    rowid_d = bus.RowId;
                    wcnt_d  = '0;
                    ccnt_d  = '0;
                    rcnt_d  = '0;
                    cdone_d = 1'b0;
                end
            end

            ST_WB_READ: begin
                lb_rd_c   = 1'b1;
                lb_addr_c = {row_q, wcnt_q};
                first_d   = 1'b1;
                state_d   = ST_WB_SEND;
            end

            ST_WB_SEND: begin
                // lb_rdata is only valid on the entry cycle: forward it then
                // and replay the captured copy for any stalled cycles.
                cmd_valid_c = 1'b1;
                cmd_we_c    = 1'b1;
                cmd_addr_c  = {rowid_q, wcnt_q};
                mem_wdata_c = first_q ? bus.lb_rdata : hold_q;
                hold_d      = mem_wdata_c;
                if (bus.mem_cmd_ready) begin
                    wcnt_d  = wcnt_q + COLWIDTH'(1);
                    state_d = (wcnt_q == '1) ? ST_DONE : ST_WB_READ;
                end
            end

            ST_AL_XFER: begin
                cmd_valid_c = !cdone_q;
                if (cmd_valid_c) begin
                    cmd_addr_c = {rowid_q, ccnt_q};
                    if (bus.mem_cmd_ready) begin
                        ccnt_d = ccnt_q + COLWIDTH'(1);
                        if (ccnt_q == '1) begin
                            cdone_d = 1'b1;
                        end
                    end
                end
                if (rsp_ok) begin
                    lb_wr_c    = 1'b1;
                    lb_addr_c  = {row_q, rcnt_q};
                    lb_wdata_c = bus.mem_rdata;
                    rcnt_d     = rcnt_q + COLWIDTH'(1);
                    if (rcnt_q == '1) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                sync_c  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sync          = sync_c;
    assign bus.busy          = busy_c;
    assign bus.lb_rd         = lb_rd_c;
    assign bus.lb_wr         = lb_wr_c;
    assign bus.lb_addr       = lb_addr_c;
    assign bus.lb_wdata      = lb_wdata_c;
    assign bus.mem_cmd_valid = cmd_valid_c;
    assign bus.mem_cmd_we    = cmd_we_c;
    assign bus.mem_cmd_addr  = cmd_addr_c;
    assign bus.mem_wdata     = mem_wdata_c;

endmodule

// File: tb/tb_mem_sync_responder.sv
// Directed bench for mem_sync_responder: a table of whole transfers, each
// driven against a local-buffer / memory model, plus reset sequences.
module tb_mem_sync_responder;
    import mem_sync_pkg::*;

    localparam int unsigned CW   = 6;
    localparam int unsigned AW   = 17;
    localparam int unsigned COLW = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned NW   = 16;

    typedef struct {
        bit                wb;
        bit                al;
        bit                keep_al;
        bit                exp_wb;
        logic [CW-1:0]     crow;
        logic [AW-1:0]     rowid;
        int unsigned       stall;
        int unsigned       rdly;
        bit                spur;
        int unsigned       min_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sync_responder_if #(.CHWIDTH(CW), .ADDRWIDTH(AW), .COLWIDTH(COLW), .DWIDTH(DW)) bus ();

    mem_sync_responder #(.CHWIDTH(CW), .ADDRWIDTH(AW), .COLWIDTH(COLW), .DWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [DW-1:0]      lbmem [0:1023];
    int unsigned        cyc = 0;
    bit                 mode_wb = 1'b0;
    bit                 quiet = 1'b0;
    logic [CW-1:0]      exp_row = '0;
    logic [AW-1:0]      exp_rowid = '0;
    int unsigned        n_wr = 0, n_rdc = 0, n_lbw = 0, n_sync = 0;
    int unsigned        stall_len = 0, stall_cnt = 0, rdly = 2;
    bit                 spur_en = 1'b0;
    int unsigned        due_q [$];
    logic [AW+COLW-1:0] addr_q [$];
    bit                 prev_rd = 1'b0;
    logic [CW+COLW-1:0] prev_rd_addr = '0;

    function automatic logic [DW-1:0] mdata(input logic [AW+COLW-1:0] a);
        return {16'hC0DE, 6'd0, a, ~a};
    endfunction

    function automatic vec_t mk(input bit wb, input bit al, input bit keep, input bit ewb,
                                input logic [CW-1:0] cr, input logic [AW-1:0] rid,
                                input int unsigned st, input int unsigned rd, input bit sp);
        vec_t v;
        v.wb = wb; v.al = al; v.keep_al = keep; v.exp_wb = ewb;
        v.crow = cr; v.rowid = rid; v.stall = st; v.rdly = rd; v.spur = sp;
        v.min_lat = ewb ? (2 * NW + 1) : (NW + 2);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, 64'({bus.sync, bus.busy, bus.lb_rd, bus.lb_wr,
                                  bus.mem_cmd_valid, bus.mem_cmd_we}), 64'd0);
        chk({name, "_addr"}, 64'({bus.lb_addr, bus.mem_cmd_addr}), 64'd0);
        chk({name, "_lb_wdata"}, bus.lb_wdata, 64'd0);
        chk({name, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    endtask

    // One cycle: drive inputs at the falling edge, sample outputs 1ns later.
    task automatic step();
        @(negedge clk);
        cyc++;
        bus.lb_rdata = prev_rd ? lbmem[prev_rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
        if (bus.mem_cmd_valid && stall_cnt < stall_len) begin
            bus.mem_cmd_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus.mem_cmd_ready = 1'b1;
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mdata(addr_q.pop_front());
        end else if (spur_en && !mode_wb && bus.busy && due_q.size() == 0 && n_rdc < NW) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 64'hBADD_0000_5EED_0000;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
        end
        #1;
        prev_rd = 1'b0;
        if (quiet) begin
            chk("quiet_ctrl", 64'({bus.sync, bus.lb_rd, bus.lb_wr, bus.mem_cmd_valid, bus.busy}), 64'd0);
        end else begin
            if (bus.mem_cmd_valid) begin
                if (mode_wb) begin
                    chk("wb_cmd_we", 64'(bus.mem_cmd_we), 64'd1);
                    chk("wb_cmd_addr", 64'(bus.mem_cmd_addr), 64'({exp_rowid, COLW'(n_wr)}));
                    chk("wb_wdata", bus.mem_wdata, lbmem[{exp_row, COLW'(n_wr)}]);
                    if (bus.mem_cmd_ready) n_wr++;
                end else begin
                    chk("al_cmd_we", 64'(bus.mem_cmd_we), 64'd0);
                    chk("al_cmd_addr", 64'(bus.mem_cmd_addr), 64'({exp_rowid, COLW'(n_rdc)}));
                    if (bus.mem_cmd_ready) begin
                        due_q.push_back(cyc + rdly);
                        addr_q.push_back(bus.mem_cmd_addr);
                        n_rdc++;
                    end
                end
                if (bus.mem_cmd_ready) stall_cnt = 0;
            end
            if (mode_wb) begin
                chk("wb_no_lb_wr", 64'(bus.lb_wr), 64'd0);
                if (bus.lb_rd) begin
                    chk("lb_rd_addr", 64'(bus.lb_addr), 64'({exp_row, COLW'(n_wr)}));
                    prev_rd      = 1'b1;
                    prev_rd_addr = bus.lb_addr;
                end
            end else begin
                chk("al_no_lb_rd", 64'(bus.lb_rd), 64'd0);
                if (bus.lb_wr) begin
                    chk("lb_wr_addr", 64'(bus.lb_addr), 64'({exp_row, COLW'(n_lbw)}));
                    chk("lb_wr_data", bus.lb_wdata, mdata({exp_rowid, COLW'(n_lbw)}));
                    n_lbw++;
                end
            end
            if (bus.sync) n_sync++;
        end
    endtask

    task automatic setup(input vec_t v);
        exp_row = v.crow; exp_rowid = v.rowid; mode_wb = v.exp_wb;
        stall_len = v.stall; rdly = v.rdly; spur_en = v.spur;
        n_wr = 0; n_rdc = 0; n_lbw = 0; n_sync = 0; stall_cnt = 0;
        due_q.delete(); addr_q.delete();
        bus.cRowId = v.crow; bus.RowId = v.rowid;
        bus.wb_req = v.wb; bus.alloc_req = v.al;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int unsigned lat = 0;
        bit got = 1'b0;
        bit busy_at_sync = 1'b0;
        setup(v);
        while (!got && lat < 400) begin
            step();
            lat++;
            // Ids are latched on leaving Idle; scramble them afterwards.
            if (lat == 2) begin
                bus.cRowId = ~v.crow;
                bus.RowId  = ~v.rowid;
            end
            if (bus.sync) begin
                got = 1'b1;
                busy_at_sync = bus.busy;
                bus.wb_req = 1'b0;
                if (!v.keep_al) bus.alloc_req = 1'b0;
            end
        end
        chk({tag, "_sync_seen"}, 64'(got), 64'd1);
        chk({tag, "_busy_at_sync"}, 64'(busy_at_sync), 64'd1);
        chk({tag, "_latency_min"}, 64'((lat >= v.min_lat) ? v.min_lat : lat), 64'(v.min_lat));
        if (v.exp_wb) begin
            chk({tag, "_wb_words"}, 64'(n_wr), 64'(NW));
        end else begin
            chk({tag, "_al_cmds"}, 64'(n_rdc), 64'(NW));
            chk({tag, "_al_words"}, 64'(n_lbw), 64'(NW));
            chk({tag, "_ccnt_wrap"}, 64'(dut.ccnt_q), 64'd0);
            chk({tag, "_rcnt_wrap"}, 64'(dut.rcnt_q), 64'd0);
        end
        if (!v.keep_al) begin
            step();
            chk({tag, "_sync_one_cycle"}, 64'(bus.sync), 64'd0);
            chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
            chk({tag, "_sync_count"}, 64'(n_sync), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [8];
        vec_t vr;
        int unsigned k;

        for (int i = 0; i < 1024; i++) begin
            lbmem[i] = {32'h1B0F_5EED, 22'd0, 10'(i)} ^ {8'd0, 14'(i * 37), 42'd0};
        end

        //        wb al keep ewb crow   rowid      stall rdly spur
        vt[0] = mk(1, 0, 0, 1, 6'd5,  17'h1A2B3, 0, 2, 0);
        vt[1] = mk(1, 0, 0, 1, 6'd12, 17'h1FFFF, 3, 2, 0);
        vt[2] = mk(0, 1, 0, 0, 6'd63, 17'h00000, 0, 2, 0);
        vt[3] = mk(1, 1, 1, 1, 6'd9,  17'h00123, 0, 2, 0);
        vt[4] = mk(0, 1, 0, 0, 6'd20, 17'h0ABCD, 0, 2, 0);
        vt[5] = mk(0, 1, 0, 0, 6'd1,  17'h15555, 0, 1, 0);
        vt[6] = mk(0, 1, 0, 0, 6'd33, 17'h0F0F0, 3, 2, 1);
        vt[7] = mk(0, 1, 0, 0, 6'd0,  17'h1FFFF, 1, 3, 0);

        bus.wb_req = 1'b1; bus.alloc_req = 1'b1;
        bus.cRowId = '1; bus.RowId = '1;
        bus.lb_rdata = '0; bus.mem_cmd_ready = 1'b1;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        rst = 1'b1;
        quiet = 1'b1;
        #1;
        chk_zero("reset");
        repeat (3) step();
        chk_zero("reset_held");
        bus.wb_req = 1'b0; bus.alloc_req = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        quiet = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an allocate, then a clean retry.
        vr = mk(0, 1, 0, 0, 6'd7, 17'h00777, 0, 2, 0);
        setup(vr);
        k = 0;
        while (n_lbw < 7 && k < 100) begin
            step();
            k++;
        end
        chk("rst_mid_word7", 64'(n_lbw), 64'd7);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        bus.alloc_req = 1'b0;
        bus.mem_rvalid = 1'b0;
        due_q.delete(); addr_q.delete();
        quiet = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        quiet = 1'b0;
        chk("rst_mid_no_sync", 64'(n_sync), 64'd0);
        run_txn(vr, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
